// File: rtl/lfsr_checker.sv
// Receive-side LFSR sequence checker: self-synchronises to the incoming state stream,
// keeps a flywheel prediction while locked and counts mispredictions (saturating).
module lfsr_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [WIDTH-1:0]     taps_i,
  input  logic [WIDTH-1:0]     data_in_i,
  input  logic                 err_clr_i,
  output logic                 locked_o,
  output logic                 error_o,
  output logic [ERR_WIDTH-1:0] err_count_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0]        LOCK_C  = MW'(LOCK_COUNT);
  localparam logic [LW-1:0]        LOSS_C  = LW'(LOSS_COUNT);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  typedef enum logic {SEARCH, LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       ref_q, ref_d;
  logic [MW-1:0]          match_q, match_d;
  logic [LW-1:0]          miss_q, miss_d;
  logic                   error_q, error_d;
  logic [ERR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       pred;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEARCH;
      ref_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pred    = {ref_q[WIDTH-2:0], ^(ref_q & taps_i)};
    state_d = state_q;
    ref_d   = ref_q;
    match_d = match_q;
    miss_d  = miss_q;
    error_d = 1'b0;
    if (en_i) begin
      unique case (state_q)
        SEARCH: begin
          ref_d = data_in_i;
          // the all-zero lockup state never counts as a match
          if (data_in_i == pred && data_in_i != '0) begin
            match_d = match_q + MW'(1);
            if (match_d == LOCK_C) begin
              state_d = LOCKED;
              match_d = '0;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (data_in_i == pred) begin
            ref_d  = data_in_i;
            miss_d = '0;
          end else begin
            // flywheel: stay on the predicted sequence until too many misses in a row
            error_d = 1'b1;
            ref_d   = pred;
            miss_d  = miss_q + LW'(1);
            if (miss_d == LOSS_C) begin
              state_d = SEARCH;
              match_d = '0;
              miss_d  = '0;
              ref_d   = data_in_i;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (err_clr_i)
      cnt_d = error_d ? ERR_WIDTH'(1) : '0;
    else if (error_d && cnt_q != ERR_MAX)
      cnt_d = cnt_q + ERR_WIDTH'(1);
    else
      cnt_d = cnt_q;
  end

  assign locked_o    = (state_q == LOCKED);
  assign error_o     = error_q;
  assign err_count_o = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a behavioural model compared every cycle plus
// hand-computed literal checkpoints on the taps=B8 sequence 01,02,04,08,11,23,47,8E.
module tb_lfsr_checker;
  localparam int LOCK = 4, LOSS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, clr = 1'b0;
  logic [7:0] taps = 8'hB8, din = 8'h00;
  logic       locked, error;
  logic [7:0] err_count;

  int n_cmp = 0, n_fail = 0;

  lfsr_checker #(.WIDTH(8), .LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .taps_i(taps), .data_in_i(din),
    .err_clr_i(clr), .locked_o(locked), .error_o(error), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tstep(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: lock tracking by counting consecutive good/bad samples.
  bit         m_lk, m_err, m_e;
  logic [7:0] m_ref, m_p;
  int         m_mc, m_ms, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lk = 0; m_err = 0; m_ref = 0; m_mc = 0; m_ms = 0; m_cnt = 0;
    end else begin
      m_e = 0;
      m_p = tstep(m_ref, taps);
      if (en) begin
        if (!m_lk) begin
          if (din == m_p && din != 0) begin
            m_mc++;
            if (m_mc == LOCK) begin m_lk = 1; m_ms = 0; end
          end else m_mc = 0;
          m_ref = din;
        end else if (din == m_p) begin
          m_ref = din; m_ms = 0;
        end else begin
          m_e = 1; m_ms++; m_ref = m_p;
          if (m_ms == LOSS) begin m_lk = 0; m_mc = 0; m_ms = 0; m_ref = din; end
        end
      end
      m_err = m_e;
      if (clr) m_cnt = m_e ? 1 : 0;
      else if (m_e && m_cnt < 255) m_cnt++;
    end
  end

  always @(negedge clk) begin
    chk("model_locked", int'(locked), int'(m_lk));
    chk("model_error", int'(error), int'(m_err));
    chk("model_err_count", int'(err_count), m_cnt);
  end

  // Called at a negedge; returns at the next negedge with the sampled result visible.
  task automatic smp(input logic [7:0] d, input logic c = 1'b0);
    en = 1'b1; din = d; clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0; clr = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rst();
    en = 1'b0; clr = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] cur;
  logic [7:0] seq[6];

  initial begin
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04;
    seq[3] = 8'h08; seq[4] = 8'h11; seq[5] = 8'h23;
    @(negedge clk);
    do_rst();
    chk("reset_locked", int'(locked), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_err_count", int'(err_count), 0);

    // 1: seed + 4 matches locks on the 5th sample
    for (int i = 0; i < 6; i++) begin
      smp(seq[i]);
      if (i == 3) chk("t1_not_locked_4th", int'(locked), 0);
      if (i == 4) chk("t1_locked_5th", int'(locked), 1);
      chk("t1_no_error", int'(error), 0);
    end
    cur = 8'h23;

    // 2: one bad sample in place of 47
    cur = tstep(cur, taps);
    chk("t2_pred_47", int'(cur), 8'h47);
    smp(8'h00);
    chk("t2_error", int'(error), 1);
    chk("t2_err_count", int'(err_count), 1);
    chk("t2_still_locked", int'(locked), 1);
    cur = tstep(cur, taps);
    chk("t2_pred_8E", int'(cur), 8'h8E);
    smp(cur);
    chk("t2_no_error_after", int'(error), 0);
    idle(1);
    en = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t2_cleared", int'(err_count), 0);

    // 3: three misses in a row drop lock, then relock
    for (int i = 0; i < 3; i++) begin
      smp(8'h55);
      chk("t3_error", int'(error), 1);
      chk("t3_locked", int'(locked), i < 2 ? 1 : 0);
    end
    chk("t3_err_count", int'(err_count), 3);
    for (int i = 0; i < 5; i++) begin
      smp(seq[i]);
      chk("t3_relock", int'(locked), i == 4 ? 1 : 0);
    end
    idle(1);

    // 4: all-zero lockup state never counts toward lock
    do_rst();
    repeat (10) begin
      smp(8'h00);
      chk("t4_zero_unlocked", int'(locked), 0);
    end
    for (int i = 0; i < 5; i++) begin
      smp(seq[i]);
      chk("t4_lock_after_zeros", int'(locked), i == 4 ? 1 : 0);
    end
    cur = 8'h11;

    // 5: saturate the error counter, then clear with a simultaneous error
    for (int k = 0; k < 150; k++) begin
      repeat (2) begin
        cur = tstep(cur, taps);
        smp(cur ^ 8'hFF);
      end
      cur = tstep(cur, taps);
      smp(cur);
    end
    chk("t5_saturated", int'(err_count), 255);
    chk("t5_locked", int'(locked), 1);
    cur = tstep(cur, taps);
    smp(cur ^ 8'hFF, 1'b1);
    chk("t5_clr_with_error", int'(err_count), 1);
    chk("t5_error_pulse", int'(error), 1);
    en = 1'b0; clr = 1'b0;

    // 6: asynchronous reset between edges, then lock with en gaps
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_locked", int'(locked), 0);
    chk("t6_async_error", int'(error), 0);
    chk("t6_async_err_count", int'(err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp(seq[i]);
      if (i == 3) chk("t6_gap_not_locked", int'(locked), 0);
      if (i == 4) chk("t6_gap_locked", int'(locked), 1);
      idle(2);
      chk("t6_gap_no_error", int'(error), 0);
    end
    chk("t6_gap_err_count", int'(err_count), 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
